// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses imem and loads the IF/ID register.
// Redirects (jump over branch) flush IF/ID and take priority over stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [5:0]  imem_a,
  input  logic [31:0] imem_rd,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic [31:0] fetch_count
);

  logic [31:0] pcplus4_f;
  logic        redirect;
  logic [31:0] redirect_pc;

  assign pcplus4_f = pc_f + 32'd4;
  assign imem_a    = pc_f[7:2];
  assign redirect  = jump | branch_taken;

  always_comb begin
    redirect_pc = jump ? jump_target : branch_target;
    redirect_pc[1:0] = 2'b00;
  end

  // IF -> ID boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f        <= RESET_PC;
      instr_d     <= NOP_INSTR;
      pcplus4_d   <= 32'd0;
      valid_d     <= 1'b0;
      fetch_count <= 32'd0;
    end else if (redirect) begin
      pc_f      <= redirect_pc;
      instr_d   <= NOP_INSTR;
      pcplus4_d <= 32'd0;
      valid_d   <= 1'b0;
    end else if (!stall_f) begin
      pc_f        <= pcplus4_f;
      instr_d     <= imem_rd;
      pcplus4_d   <= pcplus4_f;
      valid_d     <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic against a reference model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, stall_f, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [5:0]  imem_a;
  logic [31:0] imem_rd, pc_f, instr_d, pcplus4_d, fetch_count;
  logic        valid_d;

  logic [31:0] mem [64];
  int unsigned total = 0;
  int unsigned bad = 0;

  // reference state
  logic [31:0] m_pc, m_instr, m_p4, m_cnt;
  logic        m_valid;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .reset(reset), .stall_f(stall_f),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_a(imem_a), .imem_rd(imem_rd), .pc_f(pc_f),
    .instr_d(instr_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign imem_rd = mem[imem_a];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model, compare everything after the edge.
  task automatic step(input logic r, input logic st, input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    reset = r; stall_f = st; branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt;
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    end else if (j || br) begin
      m_pc = (j ? jt : bt) & 32'hFFFF_FFFC;
      m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = mem[(m_pc / 4) % 64];
      m_p4 = m_pc + 32'd4;
      m_pc = m_p4;
      m_valid = 1'b1;
      m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk); #1;
    chk("pc_f", pc_f, m_pc);
    chk("instr_d", instr_d, m_instr);
    chk("pcplus4_d", pcplus4_d, m_p4);
    chk("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
    chk("fetch_count", fetch_count, m_cnt);
    chk("imem_a", {26'd0, imem_a}, (m_pc / 4) % 64);
  endtask

  task automatic seq(); step(0, 0, 0, 0, 0, 0); endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    reset = 1; stall_f = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;

    // reset two cycles
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_pc", pc_f, 32'h0);
    chk("reset_valid", {31'd0, valid_d}, 32'd0);

    // free run to pc 0x10, then stall 3 cycles
    for (int k = 0; k < 4; k++) seq();
    chk("run_pc", pc_f, 32'h10);
    chk("run_instr", instr_d, 32'h1000_0003);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0);
    chk("stall_pc", pc_f, 32'h10);
    chk("stall_instr", instr_d, 32'h1000_0003);
    chk("stall_count", fetch_count, 32'd4);
    seq();
    chk("resume_instr", instr_d, 32'h1000_0004);
    chk("count5", fetch_count, 32'd5);

    // branch to misaligned 0x2B from pc 0x08
    step(0, 0, 0, 0, 1, 32'h8);
    step(0, 0, 1, 32'h2B, 0, 0);
    chk("br_pc", pc_f, 32'h28);
    chk("br_flush", instr_d, 32'h0);
    chk("br_valid", {31'd0, valid_d}, 32'd0);
    seq();
    chk("br_word10", instr_d, 32'h1000_000A);

    // jump beats branch and stall
    step(0, 1, 1, 32'h80, 1, 32'h40);
    chk("jmp_pc", pc_f, 32'h40);
    chk("jmp_count", fetch_count, 32'd6);

    // imem address wrap across 0x100
    step(0, 0, 0, 0, 1, 32'hF8);
    chk("wrap_a62", {26'd0, imem_a}, 32'd62);
    seq();
    chk("wrap_a63", {26'd0, imem_a}, 32'd63);
    seq();
    chk("wrap_a0", {26'd0, imem_a}, 32'd0);
    chk("wrap_pc", pc_f, 32'h100);
    chk("wrap_p4", pcplus4_d, 32'h100);
    seq();
    chk("wrap_instr", instr_d, 32'h1000_0000);

    // reset overrides stall and jump at pc 0x30
    step(0, 0, 0, 0, 1, 32'h30);
    step(1, 1, 0, 0, 1, 32'h30);
    chk("rst_pc", pc_f, 32'h0);
    chk("rst_instr", instr_d, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    seq();
    chk("post_rst_valid", {31'd0, valid_d}, 32'd1);

    // random traffic
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), $urandom,
           ($urandom_range(0, 11) == 0), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
